textbuffer_writer: RTL and testbench
====================================

Name: textbuffer_writer

Overview:
- Bus initiator that turns an ASCII byte stream into cell writes on the text buffer's CPU-side port (cs/rw/addr/di/dout).
- Implements a minimal terminal: cursor, current attribute, CR/LF/BS/FF, ESC-set-attribute, line wrap and end-of-screen handling.
- Sits between a byte source (UART RX, CPU FIFO) and the 20x15 text buffer; exports the cursor position for a hardware cursor overlay.

Parameters:
- WIDTH, 20, columns per row
- HEIGHT, 15, rows per screen
- DEFAULT_ATTR, 8'h0F, attribute at reset and after FF; [3:0] fg colour, [7:4] bg colour
- AW, $clog2(WIDTH*HEIGHT)+1, bus address width; MSB is plane select

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  byte available
- in_data  in  8  byte
- in_ready  out  1  block accepts byte this cycle
- cs  out  1  bus select
- rw  out  1  1=write, 0=read
- addr  out  AW  {plane, cell}; plane 0=char RAM, 1=attr RAM; cell=row*WIDTH+col
- di  out  8  write data
- dout  in  8  read data, valid the cycle after a read strobe
- cursor_pos  out  AW-1  current cell index

Behaviour:
- Reset (reset=0, asynchronous): cs=0, rw=0, addr=0, di=0, in_ready=0, cursor (0,0), cursor_pos=0, attr=DEFAULT_ATTR, state=CLEAR. After release: full clear screen, then IDLE.
- cs, rw, addr are registered. di is registered except in COPY_WR, where di=dout (combinational).
- Handshake: in_ready=1 only in IDLE. A byte transfers when in_valid&in_ready at a rising edge. in_ready drops the cycle after acceptance.
- States: IDLE, ESC, WR_CHAR, WR_ATTR, NEWLINE, CLEAR, COPY_RD, COPY_WR, FILL (last row).
- Byte decode from IDLE:
  - 0x0D: col=0; back to IDLE; no bus cycle.
  - 0x0A: go to NEWLINE (CR+LF).
  - 0x08: col=col-1 if col>0, else no change; no erase.
  - 0x0C: attr=DEFAULT_ATTR; go to CLEAR; cursor homes to (0,0) when CLEAR completes.
  - 0x1B: go to ESC; the next accepted byte is loaded into attr (no bus cycle); then IDLE.
  - Any other byte is printable.
- Printable byte:
  - WR_CHAR cycle: cs=1, rw=1, addr={0,pos}, di=byte.
  - WR_ATTR cycle: cs=1, rw=1, addr={1,pos}, di=attr.
  - Then, if col<WIDTH-1: col++ and go to IDLE. Otherwise go to NEWLINE.
  - Latency: acceptance edge to in_ready=1 is 3 cycles when no wrap occurs.
- NEWLINE (one cycle, no bus): col=0. If row<HEIGHT-1: row++ and go to IDLE. Otherwise end-of-screen (see Optional Feature).
- CLEAR:
  - For cell 0..WIDTH*HEIGHT-1: char write 0x20, then attr write of the current attr.
  - 2 cycles per cell, 600 cycles at defaults.
- Bus idle (cs=0) in IDLE, ESC, NEWLINE.
- No write ever targets a cell >= WIDTH*HEIGHT.
- cursor_pos always equals row*WIDTH+col of the registered cursor.
- in_valid while busy is ignored (byte held by source). Reset mid-operation aborts the operation immediately and restarts CLEAR.

Optional Feature:
- Macro: TEXTBUFFER_WRITER_SCROLL_EN.
- Defined: end-of-screen scrolls up one row.
  - For each destination cell d=0..(HEIGHT-1)*WIDTH-1, the plane sequence is COPY_RD char (cs=1, rw=0, addr={0,d+WIDTH}), then COPY_WR char (cs=1, rw=1, addr={0,d}, di=dout). The attr plane follows with the same pair.
  - 4 cycles per cell.
  - FILL then writes the last row with 0x20 and the current attr (2 cycles per cell).
  - Cursor ends at (0,HEIGHT-1).
- Undefined: end-of-screen wraps the cursor to (0,0). FILL clears row 0 only (space and current attr), then IDLE. No read cycle is ever issued (cs=1 implies rw=1).

Test Plan:
- Reset release -> exactly 600 write cycles: even cycles addr={0,n} di=0x20, odd cycles addr={1,n} di=0x0F; then in_ready=1, cursor_pos=0.
- Send 'A' (0x41) -> cycle k+1 write {0,0}=0x41, cycle k+2 write {1,0}=0x0F, cycle k+3 in_ready=1, cursor_pos=1.
- Send 0x1B,0x1E then 'B' -> writes char 0x42 and attr 0x1E at cell 0; attr stays 0x1E for later bytes.
- Send 20 printable bytes from col 0 of row 3 -> last write at cell 79; cursor_pos=80. Then 0x08 at col 0 -> cursor_pos stays 80.
- With SCROLL_EN, fill the screen with row-indexed chars, then send 0x0A on row 14:
  - Reads are seen at {0,20} then writes at {0,0} using dout.
  - Char RAM row r holds the old row r+1.
  - Row 14 is filled with 0x20; cursor_pos=280.
- Without SCROLL_EN, the same stimulus -> only row 0 is cleared (40 writes), no cs with rw=0, cursor_pos=0. Assert reset mid-scroll -> cs=0 immediately and a full 600-cycle CLEAR follows.

Source files
------------

// File: rtl/textbuffer_writer.sv
// =============================================================================
// textbuffer_writer : ASCII byte stream to text-buffer cell writes (terminal)
// Optional: TEXTBUFFER_WRITER_SCROLL_EN selects scroll-up at end of screen.
// Revision: 1.0
// =============================================================================
`default_nettype none

module textbuffer_writer #(
  parameter int         WIDTH        = 20,
  parameter int         HEIGHT       = 15,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F,
  parameter int         AW           = $clog2(WIDTH*HEIGHT)+1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          cs,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [7:0]    di,
  input  logic [7:0]    dout,
  output logic [AW-2:0] cursor_pos
);

  localparam int CW   = AW - 1;
  localparam int CNTW = AW + 1;

  localparam logic [CW-1:0]   C_WIDTH     = CW'(WIDTH);
  localparam logic [CW-1:0]   C_LAST_COL  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]   C_LAST_ROW  = CW'(HEIGHT - 1);
  localparam logic [CW-1:0]   C_LAST_BASE = CW'((HEIGHT - 1) * WIDTH);
  localparam logic [CNTW-1:0] C_CLEAR_N   = CNTW'(2 * WIDTH * HEIGHT);
  localparam logic [CNTW-1:0] C_FILL_N    = CNTW'(2 * WIDTH);
  localparam logic [CNTW-1:0] C_COPY_N    = CNTW'(2 * (HEIGHT - 1) * WIDTH);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ESC     = 4'd1;
  localparam logic [3:0] S_WR_CHAR = 4'd2;
  localparam logic [3:0] S_WR_ATTR = 4'd3;
  localparam logic [3:0] S_NEWLINE = 4'd4;
  localparam logic [3:0] S_CLEAR   = 4'd5;
  localparam logic [3:0] S_COPY_RD = 4'd6;
  localparam logic [3:0] S_COPY_WR = 4'd7;
  localparam logic [3:0] S_FILL    = 4'd8;

  logic [3:0]      r_state;
  logic [CW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [7:0]      r_attr;
  logic            r_esc_armed;
  logic [CNTW-1:0] r_cnt;
  logic [CW-1:0]   r_fill_base;
  logic [7:0]      r_di;

  logic [CW-1:0]   w_pos;
  logic [CNTW-1:0] w_cnt_nx;
  logic [AW-1:0]   w_fill_addr;
  logic [7:0]      w_fill_data;

  assign w_pos       = r_row * C_WIDTH + r_col;
  assign cursor_pos  = w_pos;
  assign in_ready    = (r_state == S_IDLE);
  assign w_cnt_nx    = r_cnt + 1'b1;
  // r_cnt walks {cell, plane}: bit 0 selects char (0) or attr (1) plane
  assign w_fill_addr = {r_cnt[0], r_fill_base + r_cnt[CW:1]};
  assign w_fill_data = r_cnt[0] ? r_attr : 8'h20;

  // Copy writes forward the read data straight from the previous read strobe
  assign di = (r_state == S_COPY_WR) ? dout : r_di;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_CLEAR;
      cs          <= 1'b0;
      rw          <= 1'b0;
      addr        <= '0;
      r_di        <= 8'h00;
      r_row       <= '0;
      r_col       <= '0;
      r_attr      <= DEFAULT_ATTR;
      r_esc_armed <= 1'b0;
      r_cnt       <= '0;
      r_fill_base <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          cs <= 1'b0;
          rw <= 1'b0;
          if (in_valid) begin
            if (r_esc_armed) begin
              r_attr      <= in_data;
              r_esc_armed <= 1'b0;
            end else begin
              case (in_data)
                8'h0D: r_col <= '0;
                8'h0A: r_state <= S_NEWLINE;
                8'h08: if (r_col != '0) r_col <= r_col - 1'b1;
                8'h0C: begin
                  r_attr      <= DEFAULT_ATTR;
                  r_cnt       <= '0;
                  r_fill_base <= '0;
                  r_state     <= S_CLEAR;
                end
                8'h1B: r_state <= S_ESC;
                default: begin
                  cs      <= 1'b1;
                  rw      <= 1'b1;
                  addr    <= {1'b0, w_pos};
                  r_di    <= in_data;
                  r_state <= S_WR_CHAR;
                end
              endcase
            end
          end
        end

        S_ESC: begin
          r_esc_armed <= 1'b1;
          r_state     <= S_IDLE;
        end

        S_WR_CHAR: begin
          addr    <= {1'b1, w_pos};
          r_di    <= r_attr;
          r_state <= S_WR_ATTR;
        end

        S_WR_ATTR: begin
          cs <= 1'b0;
          rw <= 1'b0;
          if (r_col < C_LAST_COL) begin
            r_col   <= r_col + 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_NEWLINE;
          end
        end

        S_NEWLINE: begin
          r_col <= '0;
          r_cnt <= '0;
          if (r_row < C_LAST_ROW) begin
            r_row   <= r_row + 1'b1;
            r_state <= S_IDLE;
          end else begin
`ifdef TEXTBUFFER_WRITER_SCROLL_EN
            cs      <= 1'b1;
            rw      <= 1'b0;
            addr    <= {1'b0, C_WIDTH};
            r_state <= S_COPY_RD;
`else
            r_row       <= '0;
            r_fill_base <= '0;
            r_state     <= S_FILL;
`endif
          end
        end

        // CLEAR and FILL register one write per cycle; the state entry cycle is bus-idle
        S_CLEAR, S_FILL: begin
          if (r_cnt != ((r_state == S_CLEAR) ? C_CLEAR_N : C_FILL_N)) begin
            cs    <= 1'b1;
            rw    <= 1'b1;
            addr  <= w_fill_addr;
            r_di  <= w_fill_data;
            r_cnt <= w_cnt_nx;
          end else begin
            cs      <= 1'b0;
            rw      <= 1'b0;
            r_state <= S_IDLE;
            if (r_state == S_CLEAR) begin
              r_row <= '0;
              r_col <= '0;
            end
          end
        end

        S_COPY_RD: begin
          rw      <= 1'b1;
          addr    <= {r_cnt[0], r_cnt[CW:1]};
          r_state <= S_COPY_WR;
        end

        S_COPY_WR: begin
          if (w_cnt_nx != C_COPY_N) begin
            r_cnt   <= w_cnt_nx;
            rw      <= 1'b0;
            addr    <= {w_cnt_nx[0], w_cnt_nx[CW:1] + C_WIDTH};
            r_state <= S_COPY_RD;
          end else begin
            cs          <= 1'b0;
            rw          <= 1'b0;
            r_cnt       <= '0;
            r_fill_base <= C_LAST_BASE;
            r_state     <= S_FILL;
          end
        end

        default: begin
          cs      <= 1'b0;
          rw      <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_textbuffer_writer.sv
// Bench for textbuffer_writer: directed vector table plus multi-cycle sequences.
`default_nettype none

module tb_textbuffer_writer;

  localparam int AW = 10;
  localparam int AP = 512;  // attr plane offset

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          cs;
  logic          rw;
  logic [AW-1:0] addr;
  logic [7:0]    di;
  logic [7:0]    dout = 8'h00;
  logic [AW-2:0] cursor_pos;

  textbuffer_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cs         (cs),
    .rw         (rw),
    .addr       (addr),
    .di         (di),
    .dout       (dout),
    .cursor_pos (cursor_pos)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Text buffer model and bus monitor
  logic [7:0]    mem [0:1023];
  int            cs_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [AW-1:0] first_addr, first_wr_addr, last_addr;
  logic          first_rw;
  logic [7:0]    first_wr_di, last_di;

  always @(negedge clk) begin
    if (reset && cs) begin
      if (cs_cnt == 0) begin
        first_addr = addr;
        first_rw   = rw;
      end
      cs_cnt++;
      if (rw) begin
        if (wr_cnt == 0) begin
          first_wr_addr = addr;
          first_wr_di   = di;
        end
        wr_cnt++;
        mem[addr] = di;
        last_addr = addr;
        last_di   = di;
      end else begin
        rd_cnt++;
      end
    end
  end

  always @(posedge clk) if (cs && !rw) dout <= mem[addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: in_ready timeout, got 0, expected 1", name);
  endtask

  task automatic push(input logic [7:0] b);
    bit ok;
    wait_ready(ok);
    if (!ok) begin
      timeout("push_wait");
      return;
    end
    cs_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    push(b);
    wait_ready(ok);
    if (!ok) timeout("send_done");
  endtask

  task automatic check_clear(input string tag);
    int  n = 0, bad = 0;
    bit  done = 1'b0;
    logic [AW-1:0] ea;
    logic [7:0]    ed;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (cs) begin
        ea = (n % 2) ? AW'(AP + n / 2) : AW'(n / 2);
        ed = (n % 2) ? 8'h0F : 8'h20;
        if (!rw || addr !== ea || di !== ed) bad++;
        n++;
      end else if (in_ready) begin
        done = 1'b1;
      end else if (n > 0) begin
        bad++;
      end
    end
    check({tag, "_writes"}, n, 600);
    check({tag, "_seq_errs"}, bad, 0);
    check({tag, "_ready"}, done, 1);
    check({tag, "_cursor"}, cursor_pos, 0);
  endtask

  typedef struct {
    logic [7:0] b;
    int         pos;
    int         writes;
    int         last_a;
    int         last_d;
  } vec_t;

  vec_t vt [14];

  initial begin
    int errs;
    vt[0]  = '{8'h0D, 0,  0,   0,   0};
    vt[1]  = '{8'h1B, 0,  0,   0,   0};
    vt[2]  = '{8'h1E, 0,  0,   0,   0};
    vt[3]  = '{8'h42, 1,  2,   512, 8'h1E};
    vt[4]  = '{8'h43, 2,  2,   513, 8'h1E};
    vt[5]  = '{8'h08, 1,  0,   0,   0};
    vt[6]  = '{8'h08, 0,  0,   0,   0};
    vt[7]  = '{8'h08, 0,  0,   0,   0};
    vt[8]  = '{8'h0A, 20, 0,   0,   0};
    vt[9]  = '{8'h0A, 40, 0,   0,   0};
    vt[10] = '{8'h0A, 60, 0,   0,   0};
    vt[11] = '{8'h08, 80, 0,   0,   0};
    vt[12] = '{8'h0C, 0,  600, 811, 8'h0F};
    vt[13] = '{8'h5A, 1,  2,   512, 8'h0F};

    // Reset state
    #12;
    check("rst_cs", cs, 0);
    check("rst_rw", rw, 0);
    check("rst_addr", addr, 0);
    check("rst_di", di, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_cursor", cursor_pos, 0);
    @(negedge clk) reset = 1'b1;
    check_clear("clear");

    // Single printable byte, cycle-exact
    in_data = 8'h41; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("A_c1_cs", {cs, rw}, 2'b11);
    check("A_c1_addr", addr, 0);
    check("A_c1_di", di, 8'h41);
    check("A_c1_ready", in_ready, 0);
    @(negedge clk);
    check("A_c2_cs", {cs, rw}, 2'b11);
    check("A_c2_addr", addr, AP);
    check("A_c2_di", di, 8'h0F);
    @(negedge clk);
    check("A_c3_ready", in_ready, 1);
    check("A_c3_cs", cs, 0);
    check("A_c3_cursor", cursor_pos, 1);

    for (int i = 0; i < 11; i++) begin
      send(vt[i].b);
      check($sformatf("vec%0d_pos", i), cursor_pos, vt[i].pos);
      check($sformatf("vec%0d_writes", i), wr_cnt, vt[i].writes);
      if (vt[i].writes > 0) begin
        check($sformatf("vec%0d_last_addr", i), last_addr, vt[i].last_a);
        check($sformatf("vec%0d_last_di", i), last_di, vt[i].last_d);
      end
    end
    check("B_char_cell0", mem[0], 8'h42);
    check("B_attr_cell0", mem[AP], 8'h1E);

    // 20 printables across row 3 wrap to row 4
    for (int i = 0; i < 20; i++) send(8'(8'h61 + i));
    check("row3_last_addr", last_addr, AP + 79);
    check("row3_last_di", last_di, 8'h1E);
    check("row3_cursor", cursor_pos, 80);
    check("row3_first_char", mem[60], 8'h61);
    check("row3_last_char", mem[79], 8'h74);

    for (int i = 11; i < 14; i++) begin
      send(vt[i].b);
      check($sformatf("vec%0d_pos", i), cursor_pos, vt[i].pos);
      check($sformatf("vec%0d_writes", i), wr_cnt, vt[i].writes);
      if (vt[i].writes > 0) begin
        check($sformatf("vec%0d_last_addr", i), last_addr, vt[i].last_a);
        check($sformatf("vec%0d_last_di", i), last_di, vt[i].last_d);
      end
    end

    // Fill rows 0..13 with row-indexed chars, 5 chars on row 14, then LF
    send(8'h0D);
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 20; c++) send(8'(8'h61 + r));
    check("fill_cursor", cursor_pos, 280);
    for (int c = 0; c < 5; c++) send(8'h6F);
    check("row14_cursor", cursor_pos, 285);
    send(8'h0A);

`ifdef TEXTBUFFER_WRITER_SCROLL_EN
    check("scr_writes", wr_cnt, 600);
    check("scr_reads", rd_cnt, 560);
    check("scr_first_rw", first_rw, 0);
    check("scr_first_addr", first_addr, 20);
    check("scr_first_wr_addr", first_wr_addr, 0);
    check("scr_first_wr_di", first_wr_di, 8'h62);
    check("scr_cursor", cursor_pos, 280);
    errs = 0;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 20; c++) begin
        logic [7:0] ec;
        if (r < 13) ec = 8'(8'h62 + r);
        else if (r == 13 && c < 5) ec = 8'h6F;
        else ec = 8'h20;
        if (mem[r*20+c] !== ec || mem[AP+r*20+c] !== 8'h0F) errs++;
      end
    check("scr_screen_errs", errs, 0);
`else
    check("wrap_writes", wr_cnt, 40);
    check("wrap_reads", rd_cnt, 0);
    check("wrap_first_addr", first_addr, 0);
    check("wrap_cursor", cursor_pos, 0);
    errs = 0;
    for (int c = 0; c < 20; c++)
      if (mem[c] !== 8'h20 || mem[AP+c] !== 8'h0F) errs++;
    check("wrap_row0_errs", errs, 0);
    check("wrap_row1_kept", mem[20], 8'h62);
    check("wrap_row14_kept", mem[280], 8'h6F);
    for (int r = 0; r < 14; r++) send(8'h0A);
    check("wrap_row14_cursor", cursor_pos, 280);
`endif

    // Reset in the middle of the end-of-screen operation
    push(8'h0A);
    repeat (30) @(negedge clk);
    check("mid_busy_cs", cs, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_cs", cs, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_cursor", cursor_pos, 0);
    @(negedge clk) reset = 1'b1;
    check_clear("reclear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
